sync_fifo_param: RTL
====================

Name: sync_fifo_param

Overview:
- Parametrised synchronous FIFO. Next generation of the team's 16x8 FIFO: configurable data width and depth, occupancy count output, programmable almost-full/almost-empty flags, and defined full/empty pass-through rules.
- Buffers data between a producer and a consumer in one clock domain.
- Used as the standard buffer for datapath blocks in this codebase.

Parameters:
- DATA_W, 8, data word width in bits (>=1)
- DEPTH, 16, number of entries; must be a power of two, >=2
- AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL
- AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL

Ports:
- clk  in  1  single clock, all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- wt_en  in  1  write request
- din  in  DATA_W  write data
- rd_en  in  1  read request
- dout  out  DATA_W  read data
- dout_valid  out  1  dout holds newly popped data (standard mode)
- count  out  CNT_W=$clog2(DEPTH+1)  occupancy, 0..DEPTH
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count >= AF_LEVEL
- almost_empty  out  1  count <= AE_LEVEL
- overflow  out  1  one-cycle pulse: rejected write
- underflow  out  1  one-cycle pulse: rejected read

Behaviour:
- Reset: one clock, synchronous, active-high, fixed as decided.
  - While rst is sampled high: wt_p=0, rd_p=0, count=0, dout=0, dout_valid=0, overflow=0, underflow=0.
  - So full=0, empty=1, almost_empty=1, almost_full=(AF_LEVEL==0).
  - Reset mid-operation discards all contents; memory contents are not cleared.
- Pointers:
  - wt_p and rd_p are $clog2(DEPTH) bits wide.
  - They increment by 1 on each accepted write/read and wrap DEPTH-1 -> 0 naturally.
- Accept rules:
  - rd_acc = rd_en && !empty.
  - wt_acc = wt_en && (!full || rd_acc). A write while full is accepted only if a read is accepted in the same cycle.
  - When empty, a simultaneous write is accepted but the read is rejected; there is no empty bypass in standard mode.
- Count update:
  - count += 1 on wt_acc only.
  - count -= 1 on rd_acc only.
  - count is unchanged on both or neither.
  - count never exceeds DEPTH and never goes below 0.
- Write: on wt_acc, mem[wt_p] <= din.
- Read (standard mode):
  - On rd_acc, dout <= mem[rd_p] and dout_valid <= 1. This is 1-cycle latency.
  - Otherwise dout holds its value and dout_valid <= 0.
- Error pulses:
  - overflow <= wt_en && !wt_acc.
  - underflow <= rd_en && !rd_acc.
  - The two are independent; both may pulse in the same cycle. Neither is sticky.
- Flags: full, empty, almost_full and almost_empty are combinational from the registered count.
- Assertions (simulation only):
  - count <= DEPTH.
  - full == (count==DEPTH) and empty == (count==0).
  - !(full && empty).
  - Elaboration check: DEPTH is a power of two and AE_LEVEL < AF_LEVEL <= DEPTH.

Optional Feature:
- Macro: SYNC_FIFO_FWFT_EN (first-word-fall-through).
- Defined:
  - dout continuously shows mem[rd_p] (head of queue) whenever !empty; its value when empty is don't-care.
  - dout_valid = !empty, combinational.
  - rd_en pops the head; the next word appears on the following cycle.
  - Read latency is 0. Accept, count, flag and error rules are unchanged.
- Undefined: standard registered read as described above.

Decomposition:
- Package sync_fifo_pkg holds:
  - function clog2_depth for pointer and count widths;
  - the CNT_W derivation;
  - a localparam check helper for power-of-two DEPTH.
- One sub-module: fifo_mem_2p, a DATA_W x DEPTH simple dual-port register array.
  - Synchronous write port.
  - Asynchronous read address port; the registered/FWFT choice stays in the top.
- Control logic (accept rules, pointers, count, flags, error pulses) stays in sync_fifo_param.

Test Plan (DATA_W=8, DEPTH=16, AF_LEVEL=14, AE_LEVEL=2 unless stated):
- Reset then idle -> count=0, empty=1, full=0, almost_empty=1, dout=0, dout_valid=0, no error pulses.
- Write 0x00..0x0F, then read 16 -> full=1 after the 16th write; almost_full=1 from count=14; dout sequence 0x00..0x0F, each one cycle after rd_en; empty=1 at the end.
- Full, then wt_en=1 with rd_en=0, din=0xAA -> overflow pulses 1 cycle; count stays 16; 0xAA is never read out.
- Full, then wt_en=1 and rd_en=1, din=0x55 -> both accepted; count stays 16; 0x55 is read last after draining.
- Empty, then rd_en=1 and wt_en=1, din=0x77 -> underflow pulses; count=1; the next read returns 0x77.
- 40 writes interleaved with 40 reads across pointer wrap, plus rst asserted at count=9 -> data order preserved through the wrap; after rst, count=0, empty=1, and the next write/read returns the new data.
- FWFT build: same as the previous case, plus dout=0x11 visible the cycle after writing 0x11 into an empty FIFO, with no rd_en.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// Shared width helpers and configuration checks for the parametrised synchronous FIFO.
// Imported by sync_fifo_param and fifo_mem_2p.
package sync_fifo_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 16;

    // Flag bundle kept as one struct so checkers can bind to a single signal.
    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } fifo_flags_t;

    // Ceiling log2, never below 1 so a 1-entry range still gets a real bit.
    function automatic int clog2_depth(input int n);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v << 1;
            r++;
        end
        return (r == 0) ? 1 : r;
    endfunction

    // Occupancy runs 0..DEPTH inclusive, hence the extra value.
    function automatic int cnt_width(input int depth);
        return clog2_depth(depth + 1);
    endfunction

    function automatic bit is_pow2(input int n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

    function automatic bit fifo_cfg_ok(input int depth, input int ae_level, input int af_level);
        return is_pow2(depth) && (ae_level < af_level) && (af_level <= depth);
    endfunction

endpackage

// File: rtl/fifo_mem_2p.sv
// DATA_W x DEPTH simple dual-port register array: synchronous write, asynchronous read.
// The registered versus fall-through read choice is made by the instantiating FIFO.
module fifo_mem_2p
    import sync_fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    localparam int ADDR_W = clog2_depth(DEPTH)
) (
    input  logic              clk,
    input  logic              wt_en,
    input  logic [ADDR_W-1:0] wt_addr,
    input  logic [DATA_W-1:0] wt_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // No reset on the array: contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (wt_en) begin
            mem[wt_addr] <= wt_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, almost flags and error pulses.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is a registered read.
module sync_fifo_param
    import sync_fifo_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    localparam int CNT_W   = cnt_width(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wt_en,
    input  logic [DATA_W-1:0] din,
    input  logic              rd_en,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              overflow,
    output logic              underflow
);

    localparam int PTR_W = clog2_depth(DEPTH);

    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_CNT    = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0] AE_CNT    = CNT_W'(AE_LEVEL);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

    generate
        if (!fifo_cfg_ok(DEPTH, AE_LEVEL, AF_LEVEL)) begin : g_bad_cfg
            $error("sync_fifo_param: DEPTH must be a power of two and AE_LEVEL < AF_LEVEL <= DEPTH");
        end
    endgenerate

    logic [PTR_W-1:0]  wt_p;
    logic [PTR_W-1:0]  rd_p;
    logic [CNT_W-1:0]  cnt;
    logic              rd_acc;
    logic              wt_acc;
    logic [DATA_W-1:0] mem_rd_data;
    fifo_flags_t       flags;

    // Flags decode straight from the registered count, so they change only on clock edges.
    always_comb begin
        flags              = '0;
        flags.full         = (cnt == DEPTH_CNT);
        flags.empty        = (cnt == '0);
        flags.almost_full  = (cnt >= AF_CNT);
        flags.almost_empty = (cnt <= AE_CNT);
    end

    assign count        = cnt;
    assign full         = flags.full;
    assign empty        = flags.empty;
    assign almost_full  = flags.almost_full;
    assign almost_empty = flags.almost_empty;

    // Request/accept semantics: wt_en and rd_en are requests, each taking effect only in a
    // cycle where it is accepted. A read is accepted whenever the FIFO holds data. A write is
    // accepted when there is room, or when full but a read frees a slot in the same cycle.
    // An empty FIFO never forwards a same-cycle write to the reader. Rejected requests are
    // dropped and reported by a one-cycle overflow/underflow pulse.
    assign rd_acc = rd_en && !flags.empty;
    assign wt_acc = wt_en && (!flags.full || rd_acc);

    fifo_mem_2p #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk     (clk),
        .wt_en   (wt_acc && !rst),
        .wt_addr (wt_p),
        .wt_data (din),
        .rd_addr (rd_p),
        .rd_data (mem_rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            wt_p      <= '0;
            rd_p      <= '0;
            cnt       <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wt_acc) begin
                wt_p <= wt_p + PTR_ONE;
            end
            if (rd_acc) begin
                rd_p <= rd_p + PTR_ONE;
            end
            case ({wt_acc, rd_acc})
                2'b10:   cnt <= cnt + CNT_ONE;
                2'b01:   cnt <= cnt - CNT_ONE;
                default: cnt <= cnt;
            endcase
            overflow  <= wt_en && !wt_acc;
            underflow <= rd_en && !rd_acc;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    // Head of queue is always on dout; a pop exposes the next word after the edge.
    assign dout       = mem_rd_data;
    assign dout_valid = !flags.empty;
`else
    logic [DATA_W-1:0] dout_r;
    logic              dout_valid_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_r       <= '0;
            dout_valid_r <= 1'b0;
        end else begin
            if (rd_acc) begin
                dout_r <= mem_rd_data;
            end
            dout_valid_r <= rd_acc;
        end
    end

    assign dout       = dout_r;
    assign dout_valid = dout_valid_r;
`endif

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst) begin
            a_cnt_range: assert (cnt <= DEPTH_CNT);
            a_full_dec:  assert (full == (cnt == DEPTH_CNT));
            a_empty_dec: assert (empty == (cnt == '0));
            a_excl:      assert (!(full && empty));
        end
    end
`endif

endmodule
